cdc_hazard_sequencer: RTL

Single-clock run controller for the CDC hazard-measurement datapath. It issues a programmed burst of `fire` pulses with fixed spacing, waits for the receive-side synchronizers and counters to settle, and samples the gray and naive hazard counters. It returns per-run deltas over a valid/ready result port, so repeated experiments need no counter resets.

---
 rtl/cdc_hazard_sequencer_if.sv | 30 +++
 rtl/cdc_hazard_sequencer.sv | 99 +++++++++
 2 files changed

// File: rtl/cdc_hazard_sequencer_if.sv
// rtl/cdc_hazard_sequencer_if.sv - run-control and result bundle for the hazard sequencer
interface cdc_hazard_sequencer_if #(
  parameter int CNTW = 32,
  parameter int NPW  = 16,
  parameter int GAPW = 8
);
  logic            start;
  logic            abort;
  logic [NPW-1:0]  num_pulses;
  logic [GAPW-1:0] gap;
  logic [CNTW-1:0] gcount_in;
  logic [CNTW-1:0] ncount_in;
  logic            fire;
  logic            busy;
  logic            res_valid;
  logic            res_ready;
  logic [CNTW-1:0] gdelta;
  logic [CNTW-1:0] ndelta;
  logic [NPW-1:0]  pulses_sent;

  modport master (
    output start, abort, num_pulses, gap, gcount_in, ncount_in, res_ready,
    input  fire, busy, res_valid, gdelta, ndelta, pulses_sent
  );

  modport slave (
    input  start, abort, num_pulses, gap, gcount_in, ncount_in, res_ready,
    output fire, busy, res_valid, gdelta, ndelta, pulses_sent
  );
endinterface

// File: rtl/cdc_hazard_sequencer.sv
// rtl/cdc_hazard_sequencer.sv - fire-burst run controller returning per-run hazard counter deltas
module cdc_hazard_sequencer #(
  parameter int CNTW       = 32,
  parameter int NPW        = 16,
  parameter int GAPW       = 8,
  parameter int SETTLE_CYC = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  cdc_hazard_sequencer_if.slave  bus
);

  localparam int CW = (GAPW > 8) ? GAPW : 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FIRE, S_GAP, S_SETTLE, S_CAPTURE, S_DONE
  } state_t;

  state_t          state, nxt;
  logic [NPW-1:0]  num_q, sent_q;
  logic [GAPW-1:0] gap_q;
  logic [CNTW-1:0] gsnap, nsnap, gdelta_q, ndelta_q;
  logic [CW-1:0]   cnt;
  logic            fire_q;
  logic            last_pulse, gap_end, settle_end;

  assign last_pulse = (sent_q + NPW'(1)) == num_q;
  assign gap_end    = cnt == (CW'(gap_q) - CW'(1));
  assign settle_end = cnt == CW'(SETTLE_CYC - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      fire_q <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= nxt;
      // fire mirrors the FIRE state but comes straight off a flop
      fire_q <= (nxt == S_FIRE);
      cnt    <= (nxt != state) ? '0 : cnt + CW'(1);
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (bus.start) nxt = (bus.num_pulses != '0) ? S_FIRE : S_SETTLE;
      S_FIRE: begin
        if (bus.abort || last_pulse) nxt = S_SETTLE;
        else if (gap_q != '0)        nxt = S_GAP;
        else                         nxt = S_FIRE;
      end
      S_GAP: begin
        if (bus.abort)    nxt = S_SETTLE;
        else if (gap_end) nxt = S_FIRE;
      end
      S_SETTLE:  if (settle_end) nxt = S_CAPTURE;
      S_CAPTURE: nxt = S_DONE;
      S_DONE:    if (bus.res_ready) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      num_q    <= '0;
      gap_q    <= '0;
      sent_q   <= '0;
      gsnap    <= '0;
      nsnap    <= '0;
      gdelta_q <= '0;
      ndelta_q <= '0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        num_q  <= bus.num_pulses;
        gap_q  <= bus.gap;
        gsnap  <= bus.gcount_in;
        nsnap  <= bus.ncount_in;
        sent_q <= '0;
      end
      if (state == S_FIRE) sent_q <= sent_q + NPW'(1);
      // modular subtraction absorbs counter wrap between the two samples
      if (state == S_CAPTURE) begin
        gdelta_q <= bus.gcount_in - gsnap;
        ndelta_q <= bus.ncount_in - nsnap;
      end
    end
  end

  always_comb begin
    bus.fire        = fire_q;
    bus.busy        = (state != S_IDLE);
    bus.res_valid   = (state == S_DONE);
    bus.gdelta      = gdelta_q;
    bus.ndelta      = ndelta_q;
    bus.pulses_sent = sent_q;
  end

endmodule
